// File: rtl/fdtd_pkg.sv
// Shared types and constants for the FDTD buffer writeback block.
package fdtd_pkg;

  // Kind of writeback job currently being copied out.
  typedef enum logic [1:0] {
    JOB_HY  = 2'd0,
    JOB_EZ  = 2'd1,
    JOB_SRC = 2'd2
  } job_e;

  // Writeback sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    REQ   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Buffer select encoding seen by the ping RAM.
  localparam logic BUF_SEL_HY = 1'b0;
  localparam logic BUF_SEL_EZ = 1'b1;

  // Memory words are 32 bits, so word index -> byte offset is a shift by 2.
  localparam int WORD_SHIFT = 2;

  // Bit positions of the request/pending vectors.
  localparam int PEND_HY  = 0;
  localparam int PEND_EZ  = 1;
  localparam int PEND_SRC = 2;

endpackage

// File: rtl/fdtd_req_edge.sv
// Rising-edge capture of the three writeback start levels into sticky
// pending bits. A pending bit stays set until the sequencer clears it.
module fdtd_req_edge (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] lvl_i,
  input  logic [2:0] clr_i,
  output logic [2:0] pend_o
);

  logic [2:0] lvl_q;
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] rise_w;

  assign rise_w = lvl_i & ~lvl_q;

  // Set dominates clear so a fresh edge landing in the accept cycle is kept;
  // repeated edges while already pending simply merge into the same bit.
  always_comb begin
    pend_d = (pend_q & ~clr_i) | rise_w;
  end

  // Registered level copy for edge detection, plus the pending bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lvl_q  <= 3'b000;
      pend_q <= 3'b000;
    end else begin
      lvl_q  <= lvl_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/fdtd_buf_writeback.sv
// Copies freshly computed Hy / Ez buffers (or the single source cell) from
// the local ping RAM into data memory over a req/gnt write port.
//
// Memory handshake: mem_req_o is raised with address/data/we/be stable and
// stays high (payload unchanged) until the cycle mem_gnt_i is seen high;
// that cycle completes exactly one word write.
module fdtd_buf_writeback
  import fdtd_pkg::*;
#(
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int FDTD_DATA_WIDTH   = 16,
  parameter int BUFFER_SIZE       = 50,
  parameter int MEM_ADDR_WIDTH    = 32
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         wrt_Hy_start_i,
  input  logic                         wrt_Ez_start_i,
  input  logic                         wrt_src_start_i,
  input  logic [MEM_ADDR_WIDTH-1:0]    Hy_base_addr_i,
  input  logic [MEM_ADDR_WIDTH-1:0]    Ez_base_addr_i,
  input  logic [BUFFER_ADDR_WIDTH-1:0] src_idx_i,
  output logic                         buf_rd_en_o,
  output logic                         buf_sel_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_rd_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   buf_rd_data_i,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic                         mem_we_o,
  output logic [3:0]                   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic                         wb_busy_o,
  output logic                         wb_done_o
);

  localparam int CNT_W = BUFFER_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ALIGN_MASK = ~(MEM_ADDR_WIDTH'(3));

  state_e                       state_q, state_d;
  job_e                         job_q;
  job_e                         sel_job_w;
  logic [MEM_ADDR_WIDTH-1:0]    base_q;
  logic [CNT_W-1:0]             count_q;
  logic [BUFFER_ADDR_WIDTH-1:0] idx_q;
  logic [BUFFER_ADDR_WIDTH-1:0] src_idx_q;
  logic [31:0]                  wdata_q;

  logic [2:0]                   pend_w;
  logic [2:0]                   clr_w;
  logic                         accept_w;
  logic                         last_w;
  logic                         sel_w;
  logic [BUFFER_ADDR_WIDTH-1:0] buf_idx_w;
  logic [MEM_ADDR_WIDTH-1:0]    addr_w;
  logic [31:0]                  sext_w;

  fdtd_req_edge u_req_edge (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .lvl_i  ({wrt_src_start_i, wrt_Ez_start_i, wrt_Hy_start_i}),
    .clr_i  (clr_w),
    .pend_o (pend_w)
  );

  assign accept_w  = (state_q == IDLE) && (|pend_w);
  assign last_w    = ({1'b0, idx_q} == (count_q - ONE_CNT));
  assign sel_w     = (job_q == JOB_HY) ? BUF_SEL_HY : BUF_SEL_EZ;
  // Source jobs read and write the one cell named by the latched index.
  assign buf_idx_w = (job_q == JOB_SRC) ? src_idx_q : idx_q;
  assign addr_w    = base_q + (MEM_ADDR_WIDTH'(buf_idx_w) << WORD_SHIFT);
  assign sext_w    = {{(32-FDTD_DATA_WIDTH){buf_rd_data_i[FDTD_DATA_WIDTH-1]}},
                      buf_rd_data_i};

  // Fixed-priority pick among pending jobs (Hy > Ez > src); clear only on accept.
  always_comb begin
    sel_job_w = JOB_HY;
    clr_w     = 3'b000;
    if (pend_w[PEND_HY]) begin
      sel_job_w      = JOB_HY;
      clr_w[PEND_HY] = 1'b1;
    end else if (pend_w[PEND_EZ]) begin
      sel_job_w      = JOB_EZ;
      clr_w[PEND_EZ] = 1'b1;
    end else if (pend_w[PEND_SRC]) begin
      sel_job_w       = JOB_SRC;
      clr_w[PEND_SRC] = 1'b1;
    end
    if (!accept_w) begin
      clr_w = 3'b000;
    end
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one RD / LATCH / REQ triple per word, then a DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_w) state_d = RD;
      RD:      state_d = LATCH;
      LATCH:   state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = last_w ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job context latched on accept, word data latched in LATCH, index advanced on grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      job_q     <= JOB_HY;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      src_idx_q <= '0;
      wdata_q   <= '0;
    end else begin
      if (accept_w) begin
        job_q     <= sel_job_w;
        base_q    <= ((sel_job_w == JOB_HY) ? Hy_base_addr_i : Ez_base_addr_i) & ALIGN_MASK;
        count_q   <= (sel_job_w == JOB_SRC) ? ONE_CNT : FULL_CNT;
        idx_q     <= '0;
        src_idx_q <= src_idx_i;
      end
      if (state_q == LATCH) begin
        wdata_q <= sext_w;
      end
      if ((state_q == REQ) && mem_gnt_i && !last_w) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Outputs decoded purely from state so everything is 0 in IDLE and reset.
  always_comb begin
    buf_rd_en_o   = 1'b0;
    buf_sel_o     = 1'b0;
    buf_rd_addr_o = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_be_o      = 4'h0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    wb_busy_o     = 1'b0;
    wb_done_o     = 1'b0;
    case (state_q)
      RD: begin
        buf_rd_en_o   = 1'b1;
        buf_sel_o     = sel_w;
        buf_rd_addr_o = buf_idx_w;
        wb_busy_o     = 1'b1;
      end
      LATCH: begin
        buf_sel_o = sel_w;
        wb_busy_o = 1'b1;
      end
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = 4'hF;
        mem_addr_o  = addr_w;
        mem_wdata_o = wdata_q;
        wb_busy_o   = 1'b1;
      end
      DONE: begin
        wb_busy_o = 1'b1;
        wb_done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fdtd_buf_writeback.sv
// Testbench for fdtd_buf_writeback: directed scenarios plus randomized rounds,
// all write traffic scored against a job-level model of the expected copies.
module tb_fdtd_buf_writeback;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int BS = 50;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic          wrt_Hy_start_i = 1'b0;
  logic          wrt_Ez_start_i = 1'b0;
  logic          wrt_src_start_i = 1'b0;
  logic [31:0]   Hy_base_addr_i = '0;
  logic [31:0]   Ez_base_addr_i = '0;
  logic [AW-1:0] src_idx_i = '0;
  logic          buf_rd_en_o;
  logic          buf_sel_o;
  logic [AW-1:0] buf_rd_addr_o;
  logic [DW-1:0] buf_rd_data_i = '0;
  logic          mem_req_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          wb_busy_o;
  logic          wb_done_o;

  fdtd_buf_writeback #(
    .BUFFER_ADDR_WIDTH (AW),
    .FDTD_DATA_WIDTH   (DW),
    .BUFFER_SIZE       (BS),
    .MEM_ADDR_WIDTH    (32)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .wrt_Hy_start_i  (wrt_Hy_start_i),
    .wrt_Ez_start_i  (wrt_Ez_start_i),
    .wrt_src_start_i (wrt_src_start_i),
    .Hy_base_addr_i  (Hy_base_addr_i),
    .Ez_base_addr_i  (Ez_base_addr_i),
    .src_idx_i       (src_idx_i),
    .buf_rd_en_o     (buf_rd_en_o),
    .buf_sel_o       (buf_sel_o),
    .buf_rd_addr_o   (buf_rd_addr_o),
    .buf_rd_data_i   (buf_rd_data_i),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .wb_busy_o       (wb_busy_o),
    .wb_done_o       (wb_done_o)
  );

  // ---------------- bench state ----------------
  int total = 0;
  int bad = 0;
  logic [DW-1:0] hy_buf [64];
  logic [DW-1:0] ez_buf [64];
  logic [63:0]   exp_q[$];        // {addr, data} per expected write, in order
  int            exp_bound_q[$];  // cumulative write count at each job end
  int            exp_total = 0;
  int            writes_seen = 0;
  int            dones_seen = 0;
  logic [31:0]   obs_addr[$];
  logic [31:0]   obs_data[$];
  bit            gnt_rand = 1'b0;
  int            wait_left = 0;
  bit            prev_stall = 1'b0;
  logic [31:0]   prev_addr = '0;
  logic [31:0]   prev_data = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    logic signed [31:0]   r;
    s = v;
    r = s;
    return r;
  endfunction

  // Model of one job: the list of words it must write, then its end marker.
  task automatic push_job(input int t);
    logic [31:0] b;
    if (t == 0) begin
      b = Hy_base_addr_i & 32'hFFFF_FFFC;
      for (int i = 0; i < BS; i++) exp_q.push_back({b + 32'(i * 4), sext(hy_buf[i])});
      exp_total += BS;
    end else if (t == 1) begin
      b = Ez_base_addr_i & 32'hFFFF_FFFC;
      for (int i = 0; i < BS; i++) exp_q.push_back({b + 32'(i * 4), sext(ez_buf[i])});
      exp_total += BS;
    end else begin
      b = Ez_base_addr_i & 32'hFFFF_FFFC;
      exp_q.push_back({b + 32'(int'(src_idx_i) * 4), sext(ez_buf[src_idx_i])});
      exp_total += 1;
    end
    exp_bound_q.push_back(exp_total);
  endtask

  task automatic set_levels(input logic [2:0] m);
    wrt_Hy_start_i  = m[0];
    wrt_Ez_start_i  = m[1];
    wrt_src_start_i = m[2];
  endtask

  task automatic obs_clear();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctl"}, {20'b0, buf_rd_en_o, buf_sel_o, mem_req_o, mem_we_o, mem_be_o,
                         wb_busy_o, wb_done_o, buf_rd_addr_o == '0}, 32'h1);
    check({nm, "_addr"}, mem_addr_o, 32'h0);
    check({nm, "_wdata"}, mem_wdata_o, 32'h0);
  endtask

  task automatic wait_jobs(input int target, input int budget);
    int c;
    c = 0;
    while (dones_seen < target && c < budget) begin
      @(negedge CLK); #1;
      c++;
    end
    total++;
    if (dones_seen < target) begin
      bad++;
      $display("FAIL job_timeout: got %0d done pulses, required %0d", dones_seen, target);
    end
    repeat (3) @(negedge CLK);
    #1;
    check("exp_drained", exp_q.size(), 0);
    check("idle_after", wb_busy_o, 1'b0);
    exp_q.delete();
    exp_bound_q.delete();
    exp_total = writes_seen;
  endtask

  // ---------------- ping RAM responder (1-cycle read latency) ----------------
  logic          rd_pend = 1'b0;
  logic          rd_sel_s = 1'b0;
  logic [AW-1:0] rd_addr_s = '0;
  always @(negedge CLK) begin
    rd_pend   = buf_rd_en_o;
    rd_sel_s  = buf_sel_o;
    rd_addr_s = buf_rd_addr_o;
  end
  always @(posedge CLK) begin
    #1;
    if (rd_pend) buf_rd_data_i = rd_sel_s ? ez_buf[rd_addr_s] : hy_buf[rd_addr_s];
    else         buf_rd_data_i = DW'($urandom);
  end

  // ---------------- memory grant driver ----------------
  always @(posedge CLK) begin
    #2;
    if (!gnt_rand) begin
      mem_gnt_i = 1'b1;
    end else if (mem_req_o) begin
      if (wait_left == 0) begin
        mem_gnt_i = 1'b1;
        wait_left = $urandom_range(0, 3);
      end else begin
        mem_gnt_i = 1'b0;
        wait_left--;
      end
    end else begin
      mem_gnt_i = 1'b0;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge CLK) begin
    logic [63:0] e;
    if (RST_N) begin
      check("rd_en_with_req", {31'b0, buf_rd_en_o & mem_req_o}, 32'h0);
      if (mem_req_o) begin
        check("mem_we", mem_we_o, 1'b1);
        check("mem_be", mem_be_o, 4'hF);
        if (prev_stall) begin
          check("addr_stable", mem_addr_o, prev_addr);
          check("wdata_stable", mem_wdata_o, prev_data);
        end
        if (mem_gnt_i) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr_o, mem_wdata_o);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr_o, e[63:32]);
            check("wr_data", mem_wdata_o, e[31:0]);
          end
          obs_addr.push_back(mem_addr_o);
          obs_data.push_back(mem_wdata_o);
          writes_seen++;
        end
      end
      prev_stall = mem_req_o && !mem_gnt_i;
      prev_addr  = mem_addr_o;
      prev_data  = mem_wdata_o;
      if (wb_done_o) begin
        dones_seen++;
        if (exp_bound_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done pulse, required none (t=%0t)", $time);
        end else begin
          check("done_at_write", writes_seen, exp_bound_q.pop_front());
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int d0, w0, n_first_busy, n_first_req, n_done, done_cnt, busy_cnt, act_cnt;
    bit found;

    for (int i = 0; i < 64; i++) begin
      hy_buf[i] = '0;
      ez_buf[i] = '0;
    end

    // Reset state
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    check_all_zero("reset");
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("idle_no_busy", wb_busy_o, 1'b0);

    // 1) Hy job, grant tied high, buffer[i] = i
    gnt_rand = 1'b0;
    obs_clear();
    Hy_base_addr_i = 32'h1000_0000;
    for (int i = 0; i < 64; i++) hy_buf[i] = DW'(i);
    d0 = dones_seen;
    push_job(0);
    @(posedge CLK); #1;
    wrt_Hy_start_i = 1'b1;
    n_first_busy = -1; n_first_req = -1; n_done = -1; done_cnt = 0;
    for (int n = 0; n < 170; n++) begin
      @(negedge CLK); #1;
      if (n == 2) wrt_Hy_start_i = 1'b0;
      if (wb_busy_o && n_first_busy < 0) n_first_busy = n;
      if (mem_req_o && n_first_req < 0) n_first_req = n;
      if (wb_done_o) begin
        done_cnt++;
        if (n_done < 0) n_done = n;
      end
    end
    check("hy_first_busy", n_first_busy, 2);
    check("hy_first_req", n_first_req, 4);
    check("hy_done_cycle", n_done, 152);
    check("hy_done_count", done_cnt, 1);
    check("hy_n_writes", obs_addr.size(), 50);
    check("hy_addr0", obs_addr[0], 32'h1000_0000);
    check("hy_addr49", obs_addr[49], 32'h1000_00C4);
    check("hy_data49", obs_data[49], 32'd49);
    wait_jobs(d0 + 1, 400);

    // 2) Ez job, buffer[i] = -i, random grant delay
    gnt_rand = 1'b1;
    obs_clear();
    Ez_base_addr_i = 32'h3000_0000;
    for (int i = 0; i < 64; i++) ez_buf[i] = DW'(-i);
    d0 = dones_seen;
    push_job(1);
    @(posedge CLK); #1;
    wrt_Ez_start_i = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    wrt_Ez_start_i = 1'b0;
    wait_jobs(d0 + 1, 2000);
    check("ez_n_grants", obs_addr.size(), 50);
    check("ez_data1", obs_data[1], 32'hFFFF_FFFF);
    check("ez_done_count", dones_seen - d0, 1);

    // 3) src job, then a second src edge arriving during DONE
    gnt_rand = 1'b0;
    obs_clear();
    src_idx_i = 6'd25;
    Ez_base_addr_i = 32'h2000_0000;
    ez_buf[25] = 16'h1234;
    d0 = dones_seen;
    push_job(2);
    @(posedge CLK); #1;
    wrt_src_start_i = 1'b1;
    busy_cnt = 0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge CLK); #1;
      if (n == 2) wrt_src_start_i = 1'b0;
      if (wb_busy_o) busy_cnt++;
      if (wb_done_o) found = 1'b1;
    end
    check("src_busy_cycles", busy_cnt, 4);
    push_job(2);
    wrt_src_start_i = 1'b1;
    @(posedge CLK); #1;
    wrt_src_start_i = 1'b0;
    wait_jobs(d0 + 2, 100);
    check("src_n_writes", obs_addr.size(), 2);
    check("src_addr", obs_addr[0], 32'h2000_0064);
    check("src_data", obs_data[0], 32'h0000_1234);

    // 4) all three starts together, held 4 cycles
    for (int i = 0; i < 64; i++) begin
      hy_buf[i] = DW'($urandom);
      ez_buf[i] = DW'($urandom);
    end
    Hy_base_addr_i = 32'h4000_0000;
    Ez_base_addr_i = 32'h5000_0000;
    src_idx_i = 6'd7;
    d0 = dones_seen;
    push_job(0);
    push_job(1);
    push_job(2);
    @(posedge CLK); #1;
    set_levels(3'b111);
    repeat (4) @(posedge CLK);
    #1;
    set_levels(3'b000);
    wait_jobs(d0 + 3, 2000);
    check("sim_done_count", dones_seen - d0, 3);

    // 5) reset while word 20 of a Hy job is being requested
    Hy_base_addr_i = 32'h1000_0000;
    d0 = dones_seen;
    w0 = writes_seen;
    push_job(0);
    @(posedge CLK); #1;
    wrt_Hy_start_i = 1'b1;
    @(posedge CLK); #1;
    wrt_Hy_start_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge CLK); #1;
      if (mem_req_o && writes_seen >= w0 + 21) found = 1'b1;
    end
    check("rst_reached_word20", found, 1'b1);
    RST_N = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    exp_bound_q.delete();
    exp_total = writes_seen;
    repeat (2) @(negedge CLK);
    #1;
    RST_N = 1'b1;
    act_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK); #1;
      if (wb_busy_o || mem_req_o || buf_rd_en_o) act_cnt++;
    end
    check("post_reset_quiet", act_cnt, 0);
    check("post_reset_dones", dones_seen - d0, 0);

    // 6) Hy edge during an Ez job: Hy follows after DONE plus one IDLE cycle
    gnt_rand = 1'b0;
    d0 = dones_seen;
    push_job(1);
    push_job(0);
    @(posedge CLK); #1;
    wrt_Ez_start_i = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    wrt_Ez_start_i = 1'b0;
    wrt_Hy_start_i = 1'b1;
    @(posedge CLK); #1;
    wrt_Hy_start_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge CLK); #1;
      if (wb_done_o) found = 1'b1;
    end
    check("ez_done_seen", found, 1'b1);
    @(negedge CLK); #1;
    check("gap_idle", wb_busy_o, 1'b0);
    @(negedge CLK); #1;
    check("hy_after_busy", wb_busy_o, 1'b1);
    check("hy_after_rd_en", buf_rd_en_o, 1'b1);
    check("hy_after_sel", buf_sel_o, 1'b0);
    check("hy_after_rd_addr", buf_rd_addr_o, 6'd0);
    wait_jobs(d0 + 2, 400);

    // 7) randomized rounds: a start set, then a second set while busy
    for (int r = 0; r < 8; r++) begin
      int s1, s2, first, rest, nj, hold;
      for (int i = 0; i < 64; i++) begin
        hy_buf[i] = DW'($urandom);
        ez_buf[i] = DW'($urandom);
      end
      Hy_base_addr_i = (r == 3) ? 32'hFFFF_FFF1 : $urandom;
      Ez_base_addr_i = $urandom;
      src_idx_i = AW'($urandom_range(0, 63));
      gnt_rand = 1'($urandom_range(0, 1));
      s1 = $urandom_range(1, 7);
      s2 = $urandom_range(0, 7);
      first = ((s1 & 1) != 0) ? 0 : (((s1 & 2) != 0) ? 1 : 2);
      rest = (s1 & ~(1 << first)) | s2;
      d0 = dones_seen;
      push_job(first);
      nj = 1;
      for (int t = 0; t < 3; t++) begin
        if (((rest >> t) & 1) != 0) begin
          push_job(t);
          nj++;
        end
      end
      @(posedge CLK); #1;
      set_levels(3'(s1));
      repeat (2) @(posedge CLK);
      #1;
      set_levels(3'b000);
      @(posedge CLK); #1;
      set_levels(3'(s2));
      hold = $urandom_range(1, 4);
      repeat (hold) @(posedge CLK);
      #1;
      set_levels(3'b000);
      wait_jobs(d0 + nj, 6000);
      check("rnd_done_count", dones_seen - d0, nj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
